// File: rtl/ft_register_file.sv
// ft_register_file
//   Parity-protected integer register file for the decode stage of the
//   fault-tolerant core. Word 0 reads as zero and has no storage. Each stored
//   word carries an even-parity bit that is checked on every read port and by
//   a background scrubber. A shadow bank takes checkpoints and restores the
//   main bank one word per cycle on rollback.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   test_en_i               enables fault injection
//   raddr_i / rdata_o       NUM_RPORTS combinational read ports (5-bit index)
//   rerr_o                  per-port parity mismatch of the addressed word
//   waddr_a_i/wdata_a_i/we_a_i   write port A
//   waddr_b_i/wdata_b_i/we_b_i   write port B (wins over A on same address)
//   ckpt_i                  copy next-state main bank into shadow bank
//   rollback_i              restore main bank from shadow bank
//   busy_o                  rollback in progress
//   err_valid_o/err_addr_o  sticky first scrub error and its word index
//   err_clr_i               clears the sticky scrub error
//   flip_i/flip_addr_i      inject: invert data bit 0 of a stored word
module ft_register_file #(
  parameter int RV32E      = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             test_en_i,
  input  logic [5*NUM_RPORTS-1:0]          raddr_i,
  output logic [DATA_WIDTH*NUM_RPORTS-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]            rerr_o,
  input  logic [4:0]                       waddr_a_i,
  input  logic [DATA_WIDTH-1:0]            wdata_a_i,
  input  logic                             we_a_i,
  input  logic [4:0]                       waddr_b_i,
  input  logic [DATA_WIDTH-1:0]            wdata_b_i,
  input  logic                             we_b_i,
  input  logic                             ckpt_i,
  input  logic                             rollback_i,
  output logic                             busy_o,
  output logic                             err_valid_o,
  output logic [4:0]                       err_addr_o,
  input  logic                             err_clr_i,
  input  logic                             flip_i,
  input  logic [4:0]                       flip_addr_i
);

  localparam int         NUM_WORDS = (RV32E != 0) ? 16 : 32;
  localparam logic [4:0] LAST_IDX  = 5'(NUM_WORDS - 1);

  typedef enum logic {S_IDLE, S_ROLLBACK} state_t;

  // Out-of-range addresses (upper half in RV32E) alias to word 0.
  function automatic logic [4:0] map_idx(input logic [4:0] a);
    if ((RV32E != 0) && a[4]) map_idx = 5'd0;
    else                      map_idx = a;
  endfunction

  function automatic logic parity(input logic [DATA_WIDTH-1:0] d);
    parity = ^d;
  endfunction

  state_t state_q, state_nxt;
  logic [4:0] rb_ptr_q, rb_ptr_nxt;
  logic [4:0] scrub_ptr_q;

  logic [DATA_WIDTH-1:0] main_d     [1:NUM_WORDS-1];
  logic                  main_p     [1:NUM_WORDS-1];
  logic [DATA_WIDTH-1:0] main_d_nxt [1:NUM_WORDS-1];
  logic                  main_p_nxt [1:NUM_WORDS-1];
  logic [DATA_WIDTH-1:0] shad_d     [1:NUM_WORDS-1];
  logic                  shad_p     [1:NUM_WORDS-1];

  logic       idle;
  logic [4:0] wa_idx, wb_idx, fl_idx;
  logic       do_ckpt;
  logic       scrub_en;
  logic       scrub_bad;

  assign idle     = (state_q == S_IDLE);
  assign busy_o   = (state_q == S_ROLLBACK);
  assign wa_idx   = map_idx(waddr_a_i);
  assign wb_idx   = map_idx(waddr_b_i);
  assign fl_idx   = map_idx(flip_addr_i);
  assign do_ckpt  = idle && ckpt_i && !rollback_i;
  assign scrub_en = idle && !we_a_i && !we_b_i;

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rb_ptr_q <= 5'd1;
    end else begin
      state_q  <= state_nxt;
      rb_ptr_q <= rb_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    rb_ptr_nxt = rb_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (rollback_i) begin
          state_nxt  = S_ROLLBACK;
          rb_ptr_nxt = 5'd1;
        end
      end
      S_ROLLBACK: begin
        rb_ptr_nxt = rb_ptr_q + 5'd1;
        if (rb_ptr_q == LAST_IDX) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Main bank next state: flip first, then A, then B so later sources win.
  always_comb begin
    for (int i = 1; i < NUM_WORDS; i++) begin
      main_d_nxt[i] = main_d[i];
      main_p_nxt[i] = main_p[i];
      if (idle) begin
        if (flip_i && test_en_i && (fl_idx == 5'(i)))
          main_d_nxt[i][0] = ~main_d[i][0];
        if (we_a_i && (wa_idx == 5'(i))) begin
          main_d_nxt[i] = wdata_a_i;
          main_p_nxt[i] = parity(wdata_a_i);
        end
        if (we_b_i && (wb_idx == 5'(i))) begin
          main_d_nxt[i] = wdata_b_i;
          main_p_nxt[i] = parity(wdata_b_i);
        end
      end else if (rb_ptr_q == 5'(i)) begin
        main_d_nxt[i] = shad_d[i];
        main_p_nxt[i] = shad_p[i];
      end
    end
  end

  // Storage: main and shadow banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        main_d[i] <= '0;
        main_p[i] <= 1'b0;
        shad_d[i] <= '0;
        shad_p[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        main_d[i] <= main_d_nxt[i];
        main_p[i] <= main_p_nxt[i];
        if (do_ckpt) begin
          shad_d[i] <= main_d_nxt[i];
          shad_p[i] <= main_p_nxt[i];
        end
      end
    end
  end

  // Read ports: combinational, no write bypass
  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
    logic [4:0]            ridx;
    logic [DATA_WIDTH-1:0] rd;
    logic                  re;
    assign ridx = map_idx(raddr_i[5*k +: 5]);
    always_comb begin
      rd = '0;
      re = 1'b0;
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (ridx == 5'(i)) begin
          rd = main_d[i];
          re = ^{main_d[i], main_p[i]};
        end
      end
    end
    assign rdata_o[DATA_WIDTH*k +: DATA_WIDTH] = rd;
    assign rerr_o[k] = re;
  end

  // Scrubber: checks one word per write-free idle cycle
  always_comb begin
    scrub_bad = 1'b0;
    for (int i = 1; i < NUM_WORDS; i++) begin
      if (scrub_ptr_q == 5'(i)) scrub_bad = ^{main_d[i], main_p[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_ptr_q <= 5'd1;
      err_valid_o <= 1'b0;
      err_addr_o  <= 5'd0;
    end else begin
      if (scrub_en)
        scrub_ptr_q <= (scrub_ptr_q == LAST_IDX) ? 5'd1 : scrub_ptr_q + 5'd1;
      // A fresh error in the clear cycle is captured rather than lost.
      if (scrub_en && scrub_bad && (!err_valid_o || err_clr_i)) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= scrub_ptr_q;
      end else if (err_clr_i) begin
        err_valid_o <= 1'b0;
        err_addr_o  <= 5'd0;
      end
    end
  end

endmodule
